// File: rtl/rf_pkg.sv
// Purpose: shared widths, types and helpers for the integer register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // True when a (zero-extended) register address names an implemented register.
  function automatic logic rf_in_range(input logic [31:0] addr, input int num_regs);
    return addr < 32'(num_regs);
  endfunction

endpackage

// File: rtl/rf_read_mux.sv
// Purpose: one read port of the register array, one-hot decode then AND-OR reduce.
// Latency: combinational.
// Backpressure: none; an address with no matching register yields 0.
module rf_read_mux
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          data
);

  logic [NUM_REGS-1:0] sel;

  // One-hot select; an out-of-range address matches no entry, so the OR-reduce gives 0.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (addr == ADDR_W'(i));
    end
  end

  // AND each register with its select line and OR everything together.
  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      data = data | (regs_flat[i*DATA_W +: DATA_W] & {DATA_W{sel[i]}});
    end
  end

endmodule

// File: rtl/regfile_mport.sv
// Purpose: integer register file, one write port, NUM_RD read ports, optional bypass and hardwired x0.
// Latency: reads are combinational (RD_LATENCY=0) or registered one cycle (RD_LATENCY=1).
// Backpressure: with RD_LATENCY=1 a port whose i_rs_en is low holds its output (ID stall).
module regfile_mport
  import rf_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter int RD_LATENCY = 0,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rd_wren,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  input  logic [DATA_W-1:0]             i_rd_data,
  input  logic [NUM_RD-1:0]             i_rs_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] o_rs_data
);

  // Reject configurations the output stage and port generate cannot build.
  if (RD_LATENCY > 1 || RD_LATENCY < 0) begin : g_bad_latency
    $error("regfile_mport: RD_LATENCY must be 0 or 1");
  end
  if (NUM_RD < 1) begin : g_bad_num_rd
    $error("regfile_mport: NUM_RD must be at least 1");
  end
  if (NUM_REGS < 2 || NUM_REGS > (2 ** ADDR_W)) begin : g_bad_num_regs
    $error("regfile_mport: NUM_REGS must be >= 2 and addressable by ADDR_W bits");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             wr_sel;
  logic                            wr_ok;
  logic [NUM_RD-1:0][DATA_W-1:0]   rv;

  // A write lands only outside reset, on an implemented register, and never on a hardwired x0.
  assign wr_ok = i_rd_wren && !i_rst
              && rf_in_range(32'(i_rd_addr), NUM_REGS)
              && !((ZERO_REG != 0) && (i_rd_addr == '0));

  // Write-address decoder: one-hot enable per register.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = wr_ok && (i_rd_addr == ADDR_W'(i));
    end
  end

  // Register array; reset clears every entry and outranks a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= i_rd_data;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [DATA_W-1:0] mux_data;
    logic [DATA_W-1:0] port_rv;
    logic              addr_ok;
    logic              zero_hit;
    logic              byp_hit;

    rf_read_mux #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_mux (
      .regs_flat (regs),
      .addr      (i_rs_addr[p]),
      .data      (mux_data)
    );

    // Read value: zero for unimplemented or hardwired registers, bypass data on a live write hit.
    always_comb begin
      addr_ok  = rf_in_range(32'(i_rs_addr[p]), NUM_REGS);
      zero_hit = (ZERO_REG != 0) && (i_rs_addr[p] == '0);
      byp_hit  = (BYPASS != 0) && wr_ok && (i_rd_addr == i_rs_addr[p]);
      if (!addr_ok || zero_hit) begin
        port_rv = '0;
      end else if (byp_hit) begin
        port_rv = i_rd_data;
      end else begin
        port_rv = mux_data;
      end
    end

    assign rv[p] = port_rv;
  end

  if (RD_LATENCY == 1) begin : g_lat1
    logic [NUM_RD-1:0][DATA_W-1:0] rs_q;

    // ID/EX output registers; a port with its enable low keeps its last value.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rs_q <= '0;
      end else begin
        for (int p = 0; p < NUM_RD; p++) begin
          if (i_rs_en[p]) begin
            rs_q[p] <= rv[p];
          end
        end
      end
    end

    assign o_rs_data = rs_q;
  end else begin : g_lat0
    // Load enables have no meaning for a combinational read.
    logic unused_rs_en;
    assign unused_rs_en = ^i_rs_en;
    assign o_rs_data    = rv;
  end

endmodule

// File: tb/tb_regfile_mport.sv
// Purpose: directed self-checking bench over five register-file configurations sharing one stimulus.
// Latency: checks combinational instances in-cycle and registered instances after the edge.
// Backpressure: exercises the per-port read-enable stall on the registered instances.
module tb_regfile_mport;

  localparam int AW = 5;
  localparam int DW = 32;

  logic               clk;
  logic               rst;
  logic               wren;
  logic [AW-1:0]      wa;
  logic [DW-1:0]      wd;
  logic [1:0]         rs_en;
  logic [1:0][AW-1:0] rs_addr;

  // Instance index: 0 = L0/B1/Z1/N32, 1 = L1/B1/Z1/N32, 2 = L0/B0/Z0/N24,
  //                 3 = L1/B0/Z0/N24, 4 = L0/B1/Z0/N32
  logic [1:0][DW-1:0] o [5];
  logic [DW-1:0]      e [5][2];
  logic [4:0]         m;
  string              nm;

  int vectors;
  int miscompares;

  localparam logic [4:0] COMB = 5'b10101;
  localparam logic [4:0] REGD = 5'b01010;
  localparam logic [4:0] ALL  = 5'b11111;

  regfile_mport #(.NUM_REGS(32), .RD_LATENCY(0), .BYPASS(1), .ZERO_REG(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_rd_wren(wren), .i_rd_addr(wa), .i_rd_data(wd),
    .i_rs_en(rs_en), .i_rs_addr(rs_addr), .o_rs_data(o[0]));
  regfile_mport #(.NUM_REGS(32), .RD_LATENCY(1), .BYPASS(1), .ZERO_REG(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rd_wren(wren), .i_rd_addr(wa), .i_rd_data(wd),
    .i_rs_en(rs_en), .i_rs_addr(rs_addr), .o_rs_data(o[1]));
  regfile_mport #(.NUM_REGS(24), .RD_LATENCY(0), .BYPASS(0), .ZERO_REG(0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_rd_wren(wren), .i_rd_addr(wa), .i_rd_data(wd),
    .i_rs_en(rs_en), .i_rs_addr(rs_addr), .o_rs_data(o[2]));
  regfile_mport #(.NUM_REGS(24), .RD_LATENCY(1), .BYPASS(0), .ZERO_REG(0)) u_d (
    .i_clk(clk), .i_rst(rst), .i_rd_wren(wren), .i_rd_addr(wa), .i_rd_data(wd),
    .i_rs_en(rs_en), .i_rs_addr(rs_addr), .o_rs_data(o[3]));
  regfile_mport #(.NUM_REGS(32), .RD_LATENCY(0), .BYPASS(1), .ZERO_REG(0)) u_e (
    .i_clk(clk), .i_rst(rst), .i_rd_wren(wren), .i_rd_addr(wa), .i_rd_data(wd),
    .i_rs_en(rs_en), .i_rs_addr(rs_addr), .o_rs_data(o[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; wren = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    rs_en = 2'b11; rs_addr[0] = 5'd5; rs_addr[1] = 5'd5;
    tick();
    tick();
    rst = 1'b0; wren = 1'b0;
    #1;
    nm = "reset_read"; m = ALL;
    e = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    #1;
    nm = "reset_discarded_write";
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
  endtask

  task automatic test_write_readback();
    wren = 1'b1; wa = 5'd1; wd = 32'h11111111;
    tick();
    wa = 5'd31; wd = 32'hFFFF0000;
    tick();
    wren = 1'b0; rs_addr[0] = 5'd1; rs_addr[1] = 5'd31;
    #1;
    nm = "readback_comb"; m = COMB;
    e = '{'{32'h11111111, 32'hFFFF0000}, '{32'h11111111, 32'hFFFF0000},
          '{32'h11111111, 32'h0}, '{32'h11111111, 32'h0},
          '{32'h11111111, 32'hFFFF0000}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    #1;
    nm = "readback_reg"; m = REGD;
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
  endtask

  task automatic test_bypass();
    wren = 1'b1; wa = 5'd7; wd = 32'h07070707;
    tick();
    wd = 32'hA5A5A5A5; rs_addr[0] = 5'd7; rs_addr[1] = 5'd7;
    #1;
    nm = "bypass_same_cycle"; m = COMB;
    e = '{'{32'hA5A5A5A5, 32'hA5A5A5A5}, '{32'h0, 32'h0},
          '{32'h07070707, 32'h07070707}, '{32'h0, 32'h0},
          '{32'hA5A5A5A5, 32'hA5A5A5A5}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    wren = 1'b0;
    #1;
    nm = "bypass_after_edge"; m = ALL;
    e = '{'{32'hA5A5A5A5, 32'hA5A5A5A5}, '{32'hA5A5A5A5, 32'hA5A5A5A5},
          '{32'hA5A5A5A5, 32'hA5A5A5A5}, '{32'h07070707, 32'h07070707},
          '{32'hA5A5A5A5, 32'hA5A5A5A5}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    #1;
    nm = "bypass_reg_settled"; m = REGD;
    e[3][0] = 32'hA5A5A5A5; e[3][1] = 32'hA5A5A5A5;
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
  endtask

  task automatic test_zero_reg();
    wren = 1'b1; wa = 5'd0; wd = 32'h12345678; rs_addr[0] = 5'd0; rs_addr[1] = 5'd0;
    #1;
    nm = "zero_same_cycle"; m = COMB;
    e = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0},
          '{32'h12345678, 32'h12345678}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    wren = 1'b0;
    #1;
    nm = "zero_after_write"; m = ALL;
    e = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h12345678, 32'h12345678}, '{32'h0, 32'h0},
          '{32'h12345678, 32'h12345678}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    #1;
    nm = "zero_reg_settled"; m = REGD;
    e[3][0] = 32'h12345678; e[3][1] = 32'h12345678;
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
  endtask

  task automatic test_stall_hold();
    wren = 1'b1; wa = 5'd3; wd = 32'h33;
    tick();
    wa = 5'd4; wd = 32'h44;
    tick();
    wren = 1'b0; rs_en = 2'b11; rs_addr[0] = 5'd3; rs_addr[1] = 5'd3;
    tick();
    #1;
    nm = "stall_load"; m = REGD;
    e = '{'{32'h0, 32'h0}, '{32'h33, 32'h33}, '{32'h0, 32'h0}, '{32'h33, 32'h33}, '{32'h0, 32'h0}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    rs_en = 2'b10; rs_addr[0] = 5'd4; rs_addr[1] = 5'd4;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      nm = (c == 0) ? "stall_hold_1" : "stall_hold_2"; m = ALL;
      e = '{'{32'h44, 32'h44}, '{32'h33, 32'h44}, '{32'h44, 32'h44}, '{32'h33, 32'h44},
            '{32'h44, 32'h44}};
      for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
        vectors++;
        if (o[d][p] !== e[d][p]) begin
          miscompares++;
          $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
        end
      end
    end
    rs_en = 2'b11;
    tick();
    #1;
    nm = "stall_release"; m = REGD;
    e[1][0] = 32'h44; e[3][0] = 32'h44;
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
  endtask

  task automatic test_out_of_range();
    wren = 1'b1; wa = 5'd30; wd = 32'h30303030; rs_addr[0] = 5'd30; rs_addr[1] = 5'd6;
    #1;
    nm = "oor_same_cycle"; m = COMB;
    e = '{'{32'h30303030, 32'h0}, '{32'h30303030, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0},
          '{32'h30303030, 32'h0}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    wren = 1'b0;
    #1;
    nm = "oor_after_write"; m = ALL;
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
  endtask

  task automatic test_midrun_reset();
    rs_addr[0] = 5'd1; rs_addr[1] = 5'd7;
    tick();
    #1;
    nm = "pre_reset_contents"; m = ALL;
    for (int d = 0; d < 5; d++) begin
      e[d][0] = 32'h11111111; e[d][1] = 32'hA5A5A5A5;
    end
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    nm = "midrun_reset"; m = ALL;
    e = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0}, '{32'h0, 32'h0}};
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
    tick();
    #1;
    nm = "midrun_reset_settled";
    for (int d = 0; d < 5; d++) if (m[d]) for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o[d][p] !== e[d][p]) begin
        miscompares++;
        $display("FAIL %s dut%0d port%0d got %h expected %h", nm, d, p, o[d][p], e[d][p]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; wren = 1'b0; wa = '0; wd = '0; rs_en = 2'b11;
    rs_addr[0] = '0; rs_addr[1] = '0;
    test_reset();
    test_write_readback();
    test_bypass();
    test_zero_reg();
    test_stall_hold();
    test_out_of_range();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
